// File: rtl/lock_pkg.sv
// Shared types and defaults for the combination lock controller.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_OPEN   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ALERT  = 2'd2
    } state_t;

    localparam int DEF_MAX_TRIES = 5;
    localparam int DEF_TIMEOUT_S = 9;
    localparam int DEF_TICK_DIV  = 100_000_000;

    // Decrement that holds at zero so the digit counters never wrap.
    function automatic logic [3:0] sat_dec(input logic [3:0] v, input logic en);
        return (en && v != 4'd0) ? v - 4'd1 : v;
    endfunction

endpackage

// File: rtl/lock_ctrl_sec_tick.sv
// One-second tick divider: counts clk cycles while run is high, pulses tick for one cycle.
// Tick is asserted during the cycle the count sits at TICK_DIV-1; clr restarts the count.
module sec_tick #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = run && (cnt == LAST);

endmodule

// File: rtl/lock_ctrl.sv
// Combination lock sequencer: open/locked/alert state, wrong-try count and seconds countdown.
// Level inputs act on their rising edge; all outputs decode registered state.
module lock_ctrl
    import lock_pkg::*;
#(
    parameter int KEY_W     = 4,
    parameter int MAX_TRIES = DEF_MAX_TRIES,
    parameter int TIMEOUT_S = DEF_TIMEOUT_S,
    parameter int TICK_DIV  = DEF_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_in,
    input  logic             set_key,
    input  logic             try_req,
    input  logic             relock,
    input  logic             admin_clr,
    output logic             open,
    output logic             locked,
    output logic             alert,
    output logic [3:0]       tries_left,
    output logic [3:0]       secs_left
);

    localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [3:0] SECS_INIT  = 4'(TIMEOUT_S);

    state_t             state;
    logic [KEY_W-1:0]   key_reg;
    logic               timer_run;
    logic               prev_set, prev_try, prev_relock, prev_clr;
    logic               set_e, try_e, relock_e, clr_e;
    logic               key_match, tick, tmr_run, tmr_clr;
    logic [3:0]         tries_nxt, secs_nxt;

    // Previous-value registers reset high so a level held through reset does not fire.
    assign set_e    = set_key   & ~prev_set;
    assign try_e    = try_req   & ~prev_try;
    assign relock_e = relock    & ~prev_relock;
    assign clr_e    = admin_clr & ~prev_clr;

    assign key_match = (key_in == key_reg);
    assign tmr_run   = timer_run && (state == ST_LOCKED);
    assign tmr_clr   = ((state == ST_OPEN)   && (set_e || relock_e))
                    || ((state == ST_LOCKED) && try_e && key_match)
                    || ((state == ST_ALERT)  && clr_e);

    sec_tick #(.TICK_DIV(TICK_DIV)) u_sec_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (tmr_run),
        .clr  (tmr_clr),
        .tick (tick)
    );

    assign tries_nxt = sat_dec(tries_left, try_e);
    assign secs_nxt  = sat_dec(secs_left, tick);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_OPEN;
            key_reg     <= '0;
            tries_left  <= TRIES_INIT;
            secs_left   <= SECS_INIT;
            timer_run   <= 1'b0;
            prev_set    <= 1'b1;
            prev_try    <= 1'b1;
            prev_relock <= 1'b1;
            prev_clr    <= 1'b1;
        end else begin
            prev_set    <= set_key;
            prev_try    <= try_req;
            prev_relock <= relock;
            prev_clr    <= admin_clr;
            case (state)
                ST_OPEN: begin
                    if (set_e || relock_e) begin
                        if (set_e) key_reg <= key_in;
                        state      <= ST_LOCKED;
                        tries_left <= TRIES_INIT;
                        secs_left  <= SECS_INIT;
                        timer_run  <= 1'b0;
                    end
                end
                ST_LOCKED: begin
                    // A correct try wins over a coincident tick, which is dropped.
                    if (try_e && key_match) begin
                        state      <= ST_OPEN;
                        tries_left <= TRIES_INIT;
                        secs_left  <= SECS_INIT;
                        timer_run  <= 1'b0;
                    end else begin
                        tries_left <= tries_nxt;
                        secs_left  <= secs_nxt;
                        if (try_e) timer_run <= 1'b1;
                        if (tries_nxt == 4'd0 || secs_nxt == 4'd0) state <= ST_ALERT;
                    end
                end
                ST_ALERT: begin
                    if (clr_e) begin
                        state      <= ST_LOCKED;
                        tries_left <= TRIES_INIT;
                        secs_left  <= SECS_INIT;
                        timer_run  <= 1'b0;
                    end
                end
                default: state <= ST_OPEN;
            endcase
        end
    end

    assign open   = (state == ST_OPEN);
    assign locked = ~open;
    assign alert  = (state == ST_ALERT);

endmodule
